id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the ALU. Captures decoded operands, immediate and

---
 rtl/id_ex_stage.sv | 68 ++++++
 tb/tb_id_ex_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with RAW forwarding, stall hold and flush bubble
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic [RA-1:0]    id_rs_addr,
    input  logic [RA-1:0]    id_rt_addr,
    input  logic [RA-1:0]    id_rd_addr,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic             id_use_imm,
    input  logic             id_zero_ext,
    input  logic [2:0]       id_func,
    input  logic [1:0]       id_branch,
    input  logic             id_reg_write,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             mem_reg_write,
    input  logic [RA-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [2:0]       ex_func,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA-1:0]    ex_rd_addr,
    output logic             ex_reg_write,
    output logic [1:0]       ex_branch
);
    logic             ex_fwd_ok;
    logic [WIDTH-1:0] fwd_rs, fwd_rt, ext_imm;
    assign in_ready  = ~stall | flush;
    assign ex_fwd_ok = ex_valid & ex_reg_write;
    always_comb begin
        fwd_rs  = (id_rs_addr != '0 && ex_fwd_ok && ex_rd_addr == id_rs_addr) ? alu_out :
                  (id_rs_addr != '0 && mem_reg_write && mem_rd_addr == id_rs_addr) ? mem_result : id_rs_data;
        fwd_rt  = (id_rt_addr != '0 && ex_fwd_ok && ex_rd_addr == id_rt_addr) ? alu_out :
                  (id_rt_addr != '0 && mem_reg_write && mem_rd_addr == id_rt_addr) ? mem_result : id_rt_data;
        ext_imm = id_zero_ext ? {{(WIDTH-16){1'b0}}, id_imm} : {{(WIDTH-16){id_imm[15]}}, id_imm};
    end
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_func       <= '0;
            ex_store_data <= '0;
            ex_rd_addr    <= '0;
            ex_reg_write  <= 1'b0;
            ex_branch     <= '0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_a          <= fwd_rs;
            ex_b          <= id_use_imm ? ext_imm : fwd_rt;
            ex_func       <= id_func;
            ex_store_data <= fwd_rt;
            ex_rd_addr    <= id_rd_addr;
            ex_reg_write  <= id_reg_write;
            ex_branch     <= (id_branch == 2'b11) ? 2'b00 : id_branch;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of reset, forwarding, immediates, stall, flush and bubbles
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, stall, flush;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, ex_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, alu_out, mem_result;
    logic [15:0] id_imm;
    logic        id_use_imm, id_zero_ext, id_reg_write, mem_reg_write;
    logic [2:0]  id_func, ex_func;
    logic [1:0]  id_branch, ex_branch;
    logic        ex_valid, ex_reg_write;
    logic [31:0] ex_a, ex_b, ex_store_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    id_ex_stage #(.WIDTH(32), .RA(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .flush(flush),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_zero_ext(id_zero_ext), .id_func(id_func),
        .id_branch(id_branch), .id_reg_write(id_reg_write), .alu_out(alu_out),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_func(ex_func),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] rsd, input logic [31:0] rtd, input logic [2:0] f, input logic rw);
        in_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_func = f; id_reg_write = rw;
        id_imm = '0; id_use_imm = 1'b0; id_zero_ext = 1'b0; id_branch = 2'b00;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        alu_out = '0; mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
        id(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, 3'($urandom), 1'b1);
            id_imm = 16'($urandom); id_use_imm = 1'($urandom); id_branch = 2'($urandom);
            stall = 1'($urandom); flush = 1'($urandom);
            alu_out = $urandom; mem_reg_write = 1'($urandom); mem_rd_addr = 5'($urandom); mem_result = $urandom;
            step();
        end
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_a", ex_a, 0);
        chk("rst_b", ex_b, 0);
        chk("rst_func", 32'(ex_func), 0);
        chk("rst_store", ex_store_data, 0);
        chk("rst_rd", 32'(ex_rd_addr), 0);
        chk("rst_rw", 32'(ex_reg_write), 0);
        chk("rst_branch", 32'(ex_branch), 0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_reg_write = 1'b0; alu_out = '0;
        id(1'b1, 1, 2, 3, 32'h10, 32'h20, 3'd0, 1'b1);
        step();
        chk("load_valid", 32'(ex_valid), 1);
        chk("load_a", ex_a, 32'h10);
        chk("load_b", ex_b, 32'h20);
        chk("load_store", ex_store_data, 32'h20);
        chk("load_rd", 32'(ex_rd_addr), 3);
        chk("load_rw", 32'(ex_reg_write), 1);
        // EX forwarding on rs, then register 0 never forwards
        id(1'b1, 1, 2, 5, 32'h1, 32'h2, 3'd0, 1'b1);
        step();
        id(1'b1, 5, 2, 6, 32'h99, 32'h2, 3'd0, 1'b1);
        alu_out = 32'h11;
        step();
        chk("fwd_ex_rs", ex_a, 32'h11);
        id(1'b1, 1, 2, 0, 32'h1, 32'h2, 3'd0, 1'b1);
        step();
        id(1'b1, 0, 0, 9, 32'h99, 32'h77, 3'd0, 1'b1);
        mem_reg_write = 1'b1; mem_rd_addr = 0; mem_result = 32'h22;
        step();
        chk("r0_rs", ex_a, 32'h99);
        chk("r0_rt", ex_b, 32'h77);
        mem_reg_write = 1'b0;
        // EX beats MEM, bubble EX falls back to MEM
        id(1'b1, 1, 2, 7, 32'h1, 32'h2, 3'd0, 1'b1);
        step();
        alu_out = 32'h1; mem_reg_write = 1'b1; mem_rd_addr = 7; mem_result = 32'h2;
        id(1'b1, 1, 7, 8, 32'h55, 32'h33, 3'd0, 1'b1);
        step();
        chk("prio_b", ex_b, 32'h1);
        chk("prio_store", ex_store_data, 32'h1);
        chk("prio_a", ex_a, 32'h55);
        id(1'b0, 1, 2, 8, 32'h55, 32'h33, 3'd0, 1'b1);
        step();
        chk("bub_valid", 32'(ex_valid), 0);
        chk("bub_rw", 32'(ex_reg_write), 0);
        chk("bub_rd", 32'(ex_rd_addr), 0);
        chk("bub_a", ex_a, 0);
        id(1'b1, 7, 7, 9, 32'h55, 32'h33, 3'd0, 1'b1);
        step();
        chk("mem_a", ex_a, 32'h2);
        chk("mem_b", ex_b, 32'h2);
        mem_reg_write = 1'b0;
        // immediate extension and reserved branch code
        id(1'b1, 1, 3, 11, 32'h66, 32'h44, 3'd5, 1'b1);
        id_imm = 16'h8001; id_use_imm = 1'b1; id_zero_ext = 1'b0; id_branch = 2'b11;
        step();
        chk("sext_b", ex_b, 32'hFFFF8001);
        chk("sext_store", ex_store_data, 32'h44);
        chk("sext_func", 32'(ex_func), 5);
        chk("br11", 32'(ex_branch), 0);
        id(1'b1, 1, 3, 12, 32'h66, 32'h44, 3'd2, 1'b1);
        id_imm = 16'h8001; id_use_imm = 1'b1; id_zero_ext = 1'b1; id_branch = 2'b01;
        step();
        chk("zext_b", ex_b, 32'h00008001);
        chk("br01", 32'(ex_branch), 1);
        // stall holds everything, flush overrides stall
        stall = 1'b1;
        id(1'b1, 2, 2, 13, 32'hDEAD, 32'hBEEF, 3'd4, 1'b0);
        #1;
        chk("stall_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(ex_valid), 1);
            chk("stall_a", ex_a, 32'h66);
            chk("stall_b", ex_b, 32'h00008001);
            chk("stall_rd", 32'(ex_rd_addr), 12);
            chk("stall_func", 32'(ex_func), 2);
            chk("stall_br", 32'(ex_branch), 1);
            chk("stall_ready2", 32'(in_ready), 0);
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready), 1);
        step();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_rw", 32'(ex_reg_write), 0);
        chk("flush_br", 32'(ex_branch), 0);
        chk("flush_rd", 32'(ex_rd_addr), 0);
        chk("flush_a", ex_a, 0);
        stall = 1'b0; flush = 1'b0;
        // reset wins over stall
        id(1'b1, 1, 2, 3, 32'h10, 32'h20, 3'd0, 1'b1);
        step();
        chk("pre_rst_valid", 32'(ex_valid), 1);
        stall = 1'b1; rst = 1'b1;
        step();
        chk("rst_stall_valid", 32'(ex_valid), 0);
        chk("rst_stall_a", ex_a, 0);
        stall = 1'b0; rst = 1'b0;
        // bubble slot's old rd must not forward from EX
        id(1'b1, 1, 2, 10, 32'h10, 32'h20, 3'd0, 1'b1);
        step();
        id(1'b0, 1, 2, 10, 32'h10, 32'h20, 3'd0, 1'b1);
        step();
        chk("b6_valid", 32'(ex_valid), 0);
        chk("b6_rw", 32'(ex_reg_write), 0);
        id(1'b1, 10, 2, 0, 32'h5, 32'h20, 3'd0, 1'b1);
        alu_out = 32'hAA; mem_reg_write = 1'b1; mem_rd_addr = 10; mem_result = 32'hBB;
        step();
        chk("b6_mem", ex_a, 32'hBB);
        mem_reg_write = 1'b0;
        step();
        chk("b6_rf", ex_a, 32'h5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
